// File: rtl/text_console_pkg.sv
// Shared constants, FSM state type and cell addressing for the 4x32 text console.
package text_console_pkg;

  localparam int COLS   = 32;
  localparam int ROWS   = 4;
  localparam int CHAR_W = 8;
  localparam int ROW_W  = COLS * CHAR_W;
  localparam int FLAT_W = ROWS * ROW_W;

  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_BS     = 8'h08;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_FF     = 8'h0C;
  localparam logic [7:0] CH_CURSOR = 8'h5F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    CLEAR  = 2'd2
  } state_t;

  // Row 0 / column 0 sits in the most significant byte of the flat vector.
  function automatic int cell_hi(input logic [1:0] r, input logic [4:0] c);
    return FLAT_W - 1 - int'(r) * ROW_W - int'(c) * CHAR_W;
  endfunction

endpackage

// File: rtl/text_cursor_blink.sv
// Free-running blink timer: phase_o toggles every BLINK_CYCLES clocks.
module text_cursor_blink
  import text_console_pkg::*;
#(
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic phase_o
);

  localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (cnt_q == LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/text_buffer_writer.sv
// Byte-stream to 4x32 text buffer writer with wrap, backspace, newline, scroll and clear.
// Optional blinking cursor overlay is enabled by defining TEXT_CURSOR_EN.
module text_buffer_writer
  import text_console_pkg::*;
#(
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [FLAT_W-1:0] ascii_flat,
  output logic [1:0]        cursor_row,
  output logic [4:0]        cursor_col,
  output state_t            state_o
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, and the producer must hold in_data stable
  // with in_valid high until that edge.

  logic [FLAT_W-1:0] buf_q, buf_d;
  logic [1:0]        row_q, row_d;
  logic [4:0]        col_q, col_d;
  logic [1:0]        k_q, k_d;
  state_t            state_q, state_d;

  if (BLINK_CYCLES < 1) begin : g_bad_blink
    $error("BLINK_CYCLES must be positive");
  end

  always_comb begin
    buf_d   = buf_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            buf_d[cell_hi(row_q, col_q) -: CHAR_W] = in_data;
            if (col_q == 5'd31) begin
              col_d = 5'd0;
              if (row_q == 2'd3) begin
                state_d = SCROLL;
                k_d     = 2'd0;
              end else begin
                row_d = row_q + 2'd1;
              end
            end else begin
              col_d = col_q + 5'd1;
            end
          end else begin
            case (in_data)
              CH_CR, CH_LF: begin
                col_d = 5'd0;
                if (row_q == 2'd3) begin
                  state_d = SCROLL;
                  k_d     = 2'd0;
                end else begin
                  row_d = row_q + 2'd1;
                end
              end
              CH_BS: begin
                if (col_q != 5'd0) begin
                  col_d = col_q - 5'd1;
                  buf_d[cell_hi(row_q, col_q - 5'd1) -: CHAR_W] = CH_SPACE;
                end else if (row_q != 2'd0) begin
                  row_d = row_q - 2'd1;
                  col_d = 5'd31;
                  buf_d[cell_hi(row_q - 2'd1, 5'd31) -: CHAR_W] = CH_SPACE;
                end
              end
              CH_FF: begin
                state_d = CLEAR;
                k_d     = 2'd0;
              end
              default: ;
            endcase
          end
        end
      end
      SCROLL: begin
        // One row moves up per cycle; the last cycle blanks the bottom row.
        for (int r = 0; r < ROWS - 1; r++) begin
          if (k_q == 2'(r))
            buf_d[cell_hi(2'(r), 5'd0) -: ROW_W] = buf_q[cell_hi(2'(r + 1), 5'd0) -: ROW_W];
        end
        if (k_q == 2'd3) begin
          buf_d[cell_hi(2'd3, 5'd0) -: ROW_W] = {COLS{CH_SPACE}};
          state_d = IDLE;
        end
        k_d = k_q + 2'd1;
      end
      CLEAR: begin
        for (int r = 0; r < ROWS; r++) begin
          if (k_q == 2'(r))
            buf_d[cell_hi(2'(r), 5'd0) -: ROW_W] = {COLS{CH_SPACE}};
        end
        if (k_q == 2'd3) begin
          row_d   = 2'd0;
          col_d   = 5'd0;
          state_d = IDLE;
        end
        k_d = k_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q   <= {(ROWS * COLS){CH_SPACE}};
      row_q   <= 2'd0;
      col_q   <= 5'd0;
      k_q     <= 2'd0;
      state_q <= IDLE;
    end else begin
      buf_q   <= buf_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      state_q <= state_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign state_o    = state_q;

`ifdef TEXT_CURSOR_EN
  logic blink_phase;

  text_cursor_blink #(
    .BLINK_CYCLES(BLINK_CYCLES)
  ) u_blink (
    .clk    (clk),
    .rst_n  (rst_n),
    .phase_o(blink_phase)
  );

  // Overlay only touches the output view; the stored cell keeps its character.
  always_comb begin
    ascii_flat = buf_q;
    if (blink_phase && state_q == IDLE)
      ascii_flat[cell_hi(row_q, col_q) -: CHAR_W] = CH_CURSOR;
  end
`else
  assign ascii_flat = buf_q;
`endif

endmodule

// File: tb/tb_text_buffer_writer.sv
// Self-checking bench for text_buffer_writer: directed cases plus random bytes
// compared against a cell-array model of the console.
module tb_text_buffer_writer;
  import text_console_pkg::*;

  localparam int BLINK = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic [1023:0] ascii_flat;
  logic [1:0]    cursor_row;
  logic [4:0]    cursor_col;
  state_t        state_o;

  always #5 clk = ~clk;

  text_buffer_writer #(.BLINK_CYCLES(BLINK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ascii_flat(ascii_flat),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col),
    .state_o   (state_o)
  );

  int cyc;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- reference model ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_cell [4][32];
  int         m_r, m_c;
  logic [7:0] exp_q [$];

  function automatic void model_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 32; c++) m_cell[r][c] = 8'h20;
    m_r = 0;
    m_c = 0;
  endfunction

  function automatic void model_scroll();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 32; c++) m_cell[r][c] = m_cell[r+1][c];
    for (int c = 0; c < 32; c++) m_cell[3][c] = 8'h20;
  endfunction

  // Applies one accepted byte; returns the number of stall cycles expected.
  function automatic int model_apply(input logic [7:0] b);
    int stall = 0;
    int pos;
    if (b >= 8'h20 && b <= 8'h7E) begin
      m_cell[m_r][m_c] = b;
      if (m_c == 31) begin
        m_c = 0;
        if (m_r == 3) begin model_scroll(); stall = 4; end
        else m_r++;
      end else m_c++;
    end else if (b == 8'h0D || b == 8'h0A) begin
      m_c = 0;
      if (m_r == 3) begin model_scroll(); stall = 4; end
      else m_r++;
    end else if (b == 8'h08) begin
      pos = m_r * 32 + m_c;
      if (pos > 0) begin
        pos--;
        m_r = pos / 32;
        m_c = pos % 32;
        m_cell[m_r][m_c] = 8'h20;
      end
    end else if (b == 8'h0C) begin
      model_reset();
      stall = 4;
    end
    return stall;
  endfunction

  function automatic logic [1023:0] model_flat(input bit cur);
    logic [1023:0] f;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 32; c++) f[1023 - r*256 - c*8 -: 8] = m_cell[r][c];
    if (cur) f[1023 - m_r*256 - m_c*8 -: 8] = 8'h5F;
    return f;
  endfunction

  // ---------------- checkers ----------------
  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_flat(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int bad = -1;
    checks++;
    for (int i = 127; i >= 0; i--)
      if (obs[i*8 +: 8] !== exp[i*8 +: 8]) bad = 127 - i;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cell(%0d,%0d) observed=%02h expected=%02h t=%0t", tag, bad / 32, bad % 32,
             obs[1023 - bad*8 -: 8], exp[1023 - bad*8 -: 8], $time);
    end
  endtask

  task automatic check_state(input string tag);
    bit cur;
`ifdef TEXT_CURSOR_EN
    cur = ((cyc / BLINK) % 2) == 1;
`else
    cur = 1'b0;
`endif
    chk_flat({tag, "_flat"}, ascii_flat, model_flat(cur));
    chk_int({tag, "_row"}, int'(cursor_row), m_r);
    chk_int({tag, "_col"}, int'(cursor_col), m_c);
  endtask

  // Expects in_ready low for 'st' cycles then high, then checks buffer/cursor.
  task automatic check_stall(input int st, input string tag);
    for (int i = 0; i < st; i++) begin
      @(negedge clk);
      chk_int({tag, "_stall_ready"}, int'(in_ready), 0);
    end
    @(negedge clk);
    chk_int({tag, "_ready"}, int'(in_ready), 1);
    check_state(tag);
  endtask

  // ---------------- driver ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    int n = 0;
    int st;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_int({tag, "_accept_wait"}, int'(n < 50), 1);
    exp_q.push_back(b);
    @(posedge clk);
    st = model_apply(exp_q.pop_front());
    #1 in_valid = 1'b0;
    check_stall(st, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st;
    logic [7:0] b;

    // Reset values
    do_reset();
    @(negedge clk);
    chk_int("rst_ready", int'(in_ready), 1);
    chk_int("rst_state", int'(state_o), int'(IDLE));
    check_state("rst");

    // Backspace at (0,0) does nothing
    send(8'h08, "bs_origin");

    // "HI"
    send(8'h48, "hi_h");
    send(8'h49, "hi_i");

    // Row of 'A' wraps to (1,0), then backspace across the row boundary
    do_reset();
    for (int i = 0; i < 32; i++) send(8'h41, "row_a");
    send(8'h08, "bs_wrap");

    // Fill all rows; the final character at (3,31) scrolls; then CR scrolls again
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 32; c++) send(8'h30 + 8'(r), "fill");
    send(8'h0D, "cr_scroll");

    // Form feed with the next byte held on in_valid through the stall
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h0C;
    @(posedge clk);
    st = model_apply(8'h0C);
    #1 in_data = 8'h5A;
    check_stall(st, "ff_held");
    @(posedge clk);
    st = model_apply(8'h5A);
    #1 in_valid = 1'b0;
    check_stall(st, "after_ff");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: b = 8'($urandom_range(32, 126));
        5:             b = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
        6, 7:          b = 8'h08;
        8:             b = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h0D;
        default:       b = 8'($urandom_range(0, 255));
      endcase
      send(b, "rand");
    end

    // Reset during the second SCROLL cycle
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h0A, "to_row3");
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h0A;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk_int("mid_scroll_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    check_stall(0, "mid_scroll_rst");
    send(8'h07, "bell_ignored");

`ifdef TEXT_CURSOR_EN
    // Blink phase from reset: 4 cycles space, 4 cycles cursor, alternating
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk_int("blink_cell", int'(ascii_flat[1023 -: 8]), ((i / 4) % 2 == 1) ? 8'h5F : 8'h20);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
